// File: rtl/countdown_timer_ctrl_if.sv
// Timer control bundle between the countdown timer FSM and its surroundings.
// Carries start/stop/config requests in and counter load + status out.
// No flow control: every signal is sampled or updated once per clock.
interface countdown_timer_ctrl_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  start;
    logic                  stop;
    logic                  mode;
    logic [DATA_WIDTH-1:0] period;
    logic [DATA_WIDTH-1:0] count_q;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] d;
    logic                  busy;
    logic                  expire;
    logic                  fault;

    // Environment side: issues requests, returns the counter value.
    modport master (
        output start, stop, mode, period, count_q,
        input  load_en, d, busy, expire, fault
    );

    // Controller side.
    modport slave (
        input  start, stop, mode, period, count_q,
        output load_en, d, busy, expire, fault
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// One-shot / periodic timer FSM driving an external loadable down-counter.
// Latency: expire pulses P+1 cycles after the start-sampling edge; all outputs registered.
// No backpressure: start/stop are sampled every cycle, stop beats start.
module countdown_timer_ctrl #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    countdown_timer_ctrl_if.slave  tmr_if
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_EXPIRE = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_period;
    logic                  r_mode;
    logic                  r_fault;
    logic                  r_load_en;
    logic [DATA_WIDTH-1:0] r_d;
    logic                  r_busy;
    logic                  r_expire;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_period_nxt;
    logic                  w_mode_nxt;
    logic                  w_fault_nxt;

    // Next-state selection: stop, then start (bad or good period), then per-state progress.
    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_mode_nxt   = r_mode;
        w_fault_nxt  = r_fault;
        if (tmr_if.stop) begin
            w_state_nxt = ST_IDLE;
        end else if (tmr_if.start && (tmr_if.period == '0)) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
        end else if (tmr_if.start) begin
            w_period_nxt = tmr_if.period;
            w_mode_nxt   = tmr_if.mode;
            w_fault_nxt  = 1'b0;
            w_state_nxt  = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (tmr_if.count_q == DATA_WIDTH'(1)) begin
                        w_state_nxt = ST_EXPIRE;
                    end else if (tmr_if.count_q == '0) begin
                        // Counter reached zero without passing through 1: it is out of step.
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXPIRE: w_state_nxt = r_mode ? ST_RUN : ST_IDLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, captured config and outputs registered together; outputs decode the next state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_mode    <= 1'b0;
            r_fault   <= 1'b0;
            r_load_en <= 1'b1;
            r_d       <= '0;
            r_busy    <= 1'b0;
            r_expire  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_period  <= w_period_nxt;
            r_mode    <= w_mode_nxt;
            r_fault   <= w_fault_nxt;
            // The counter has no enable, so it is held by loading in every non-RUN state.
            r_load_en <= (w_state_nxt != ST_RUN);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_expire  <= (w_state_nxt == ST_EXPIRE);
            case (w_state_nxt)
                ST_LOAD:   r_d <= w_period_nxt;
                // Periodic reload goes straight from 0 to P so the counter never wraps.
                ST_EXPIRE: r_d <= w_mode_nxt ? w_period_nxt : '0;
                default:   r_d <= '0;
            endcase
        end
    end

    assign tmr_if.load_en = r_load_en;
    assign tmr_if.d       = r_d;
    assign tmr_if.busy    = r_busy;
    assign tmr_if.expire  = r_expire;
    assign tmr_if.fault   = r_fault;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl with a behavioural down-counter attached.
// Expected outputs come from an elapsed-cycle timer model, checked every cycle.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_countdown_timer_ctrl;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_ctrl_if #(.DATA_WIDTH(DW)) tmr_if ();

    countdown_timer_ctrl #(.DATA_WIDTH(DW)) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .tmr_if (tmr_if.slave)
    );

    // Loadable down-counter with no enable, as seen by the controller.
    logic [DW-1:0] cnt;
    logic          force0;
    assign tmr_if.count_q = force0 ? '0 : cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               cnt <= '0;
        else if (tmr_if.load_en)  cnt <= tmr_if.d;
        else                      cnt <= cnt - DW'(1);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Timer model: k = edges since the accepted start; period of the cycle is P+1.
    bit m_active;
    int m_k;
    int m_p;
    bit m_mode;
    bit m_fault;

    function automatic bit m_expire_now();
        return m_active && (m_k >= 1) && ((m_k % (m_p + 1)) == 0);
    endfunction

    function automatic bit m_running();
        return m_active && (m_k >= 1) && ((m_k % (m_p + 1)) != 0);
    endfunction

    task automatic check_outputs();
        int exp_d;
        exp_d = 0;
        if (m_active && m_k == 0)          exp_d = m_p;
        else if (m_expire_now() && m_mode) exp_d = m_p;
        chk("load_en", int'(tmr_if.load_en), int'(!m_running()));
        chk("d",       int'(tmr_if.d),       exp_d);
        chk("busy",    int'(tmr_if.busy),    int'(m_active));
        chk("expire",  int'(tmr_if.expire),  int'(m_expire_now()));
        chk("fault",   int'(tmr_if.fault),   int'(m_fault));
        if (m_running())
            chk("count_q", int'(cnt), m_p + 1 - (m_k % (m_p + 1)));
        else if (m_expire_now())
            chk("count_q_exp", int'(cnt), 0);
    endtask

    task automatic model_step(input bit st, input bit sp, input bit md, input int pd, input int cq);
        if (sp) begin
            m_active = 1'b0;
        end else if (st && pd == 0) begin
            m_fault  = 1'b1;
            m_active = 1'b0;
        end else if (st) begin
            m_active = 1'b1;
            m_k      = 0;
            m_p      = pd;
            m_mode   = md;
            m_fault  = 1'b0;
        end else if (m_active) begin
            if (m_running() && cq == 0) begin
                m_fault  = 1'b1;
                m_active = 1'b0;
            end else begin
                m_k++;
                if (!m_mode && m_k > m_p + 1) m_active = 1'b0;
            end
        end
    endtask

    // One clock: check current outputs, drive new inputs, advance the model, move to next falling edge.
    task automatic step(input bit st, input bit sp, input bit md, input int pd, input bit fz);
        check_outputs();
        tmr_if.start  = st;
        tmr_if.stop   = sp;
        tmr_if.mode   = md;
        tmr_if.period = DW'(pd);
        force0        = fz;
        #1;
        model_step(st, sp, md, pd, int'(tmr_if.count_q));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        reset         = 1'b0;
        tmr_if.start  = 1'b0;
        tmr_if.stop   = 1'b0;
        tmr_if.mode   = 1'b0;
        tmr_if.period = '0;
        force0        = 1'b0;
        m_active = 1'b0; m_k = 0; m_p = 0; m_mode = 1'b0; m_fault = 1'b0;

        #12;
        chk("rst_load_en", int'(tmr_if.load_en), 1);
        chk("rst_d",       int'(tmr_if.d),       0);
        chk("rst_busy",    int'(tmr_if.busy),    0);
        chk("rst_expire",  int'(tmr_if.expire),  0);
        chk("rst_fault",   int'(tmr_if.fault),   0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // One-shot P=3.
        step(1'b1, 1'b0, 1'b0, 3, 1'b0);
        idle(7);

        // Periodic P=2 for 12 cycles, then stop.
        step(1'b1, 1'b0, 1'b1, 2, 1'b0);
        idle(12);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(3);

        // Zero period faults; a good start clears it.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 5, 1'b0);
        idle(8);

        // Periodic P=7, restart with P=4 exactly when count_q is 1.
        step(1'b1, 1'b0, 1'b1, 7, 1'b0);
        idle(7);
        chk("restart_cq", int'(cnt), 1);
        step(1'b1, 1'b0, 1'b1, 4, 1'b0);
        idle(12);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);

        // start and stop together, from idle and from a running timer.
        step(1'b1, 1'b1, 1'b0, 5, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 5, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 3, 1'b0);
        idle(2);

        // Asynchronous reset mid-run at count_q = 5.
        step(1'b1, 1'b0, 1'b0, 9, 1'b0);
        idle(5);
        chk("prerst_cq", int'(cnt), 5);
        #1 reset = 1'b0;
        #1;
        m_active = 1'b0; m_fault = 1'b0;
        chk("arst_load_en", int'(tmr_if.load_en), 1);
        chk("arst_d",       int'(tmr_if.d),       0);
        chk("arst_busy",    int'(tmr_if.busy),    0);
        chk("arst_expire",  int'(tmr_if.expire),  0);
        chk("arst_fault",   int'(tmr_if.fault),   0);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // Counter out of step during RUN.
        step(1'b1, 1'b0, 1'b0, 6, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit st, sp, md, fz;
            int pd;
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 63) == 0);
            md = 1'($urandom_range(0, 1));
            pd = $urandom_range(0, 15);
            fz = ($urandom_range(0, 99) == 0);
            step(st, sp, md, pd, fz);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Control FSM that wraps the team's loadable down-counter to form a one-shot or periodic timer. It drives the counter's `load_en`/`d` inputs and watches its `q` output, so it sits both upstream (load path) and downstream (terminal-count detection) of the counter. It emits a single-cycle `expire` pulse each time the programmed period elapses. The counter itself has no enable, so this block holds it by keeping `load_en` asserted whenever the timer is not running.

## Interface
- `data_width`, 4: width of `period`, `count_q` and `d`; must match the counter's `data_width`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `start`  in  1  start/restart request, sampled on `clk` rise.
- `stop`  in  1  abort request; has priority over `start`.
- `mode`  in  1  0 = one-shot, 1 = periodic; captured with `period` at start.
- `period`  in  `data_width`  terminal count P, 1..2^data_width-1; captured at start.
- `count_q`  in  `data_width`  counter `q`.
- `load_en`  out  1  to counter `load_en`.
- `d`  out  `data_width`  to counter `d`.
- `busy`  out  1  high in LOAD, RUN and EXPIRE.
- `expire`  out  1  one-cycle pulse at terminal count.
- `fault`  out  1  sticky error flag.

## Operation
- Registered state: `state` (IDLE, LOAD, RUN, EXPIRE), `period_reg`, `mode_reg`, `fault`.
- All outputs are decoded from registered state only; there is no combinational path from `count_q` or `start` to any output.
- Output decode by state:
  - IDLE: `load_en`=1, `d`=0, `busy`=0, `expire`=0. The counter is held at 0.
  - LOAD: `load_en`=1, `d`=`period_reg`, `busy`=1.
  - RUN: `load_en`=0, `busy`=1. The counter decrements every cycle.
  - EXPIRE: `load_en`=1, `d`=(`mode_reg` ? `period_reg` : 0), `busy`=1, `expire`=1.
- Transitions, evaluated in priority order:
  - `stop`=1 in any state: go to IDLE.
  - `start`=1 with `period`==0: set `fault`=1 and go to IDLE (this also aborts a running timer).
  - `start`=1 with `period`!=0 in any state: capture `period` and `mode`, clear `fault`, go to LOAD. This restarts a running timer with no `expire` for the aborted run.
  - LOAD: go to RUN.
  - RUN, `count_q`==1: go to EXPIRE.
  - RUN, `count_q`==0: underflow/consistency error. Set `fault`=1 and go to IDLE with no `expire`.
  - RUN, any other value: stay in RUN.
  - EXPIRE: go to RUN if `mode_reg`=1, otherwise go to IDLE.
- Arithmetic: none beyond compares; `period_reg` has the same width as `period`, and no wrap is possible for P ≤ 2^data_width-1.
- Reset (asynchronous, while `reset`=0):
  - state IDLE, `period_reg`=0, `mode_reg`=0, `fault`=0.
  - Outputs therefore read `load_en`=1, `d`=0, `busy`=0, `expire`=0.
  - Reset mid-run abandons the run immediately, with no `expire`.

## Timing
- Edge E0 is the edge that samples `start`. State is LOAD after E0, and the counter holds P after E0+1.
- One-shot: RUN lasts P cycles (`count_q` = P..1). EXPIRE is the cycle after E0+P+1, with `count_q`=0. IDLE follows after E0+P+2.
  - Latency from start to `expire` is P+1 cycles.
- Periodic: `expire` pulses every P+1 cycles. The counter is reloaded directly from 0 to P and never wraps to all-ones.
- `busy` rises one cycle after E0 and falls one cycle after the final EXPIRE.
- `stop` takes effect on the next edge. If that edge ends an EXPIRE cycle, that `expire` has already been seen; no further pulses follow.
- `start` and `count_q`==1 in the same RUN cycle: the restart wins and no `expire` is produced for that cycle.

## Test plan
- One-shot, P=3, `mode`=0, start at E0:
  - states LOAD, RUN×3 (`count_q`=3,2,1), EXPIRE (`count_q`=0), IDLE.
  - exactly one `expire`, at E0+4..E0+5.
  - `busy` high for 5 cycles.
- Periodic, P=2, `mode`=1, run for 12 cycles:
  - `expire` every 3 cycles.
  - `count_q` sequence 2,1,0,2,1,0…; never 15.
- P=0 start: `fault`=1, state stays IDLE, `busy`=0. A subsequent start with P=5 clears `fault` and `expire` arrives after 6 cycles.
- Restart and stop:
  - Periodic P=7. At `count_q`=1, assert `start` with P=4: no `expire`; the next `expire` arrives 5 cycles later.
  - `start`=`stop`=1 together: the block stays in or returns to IDLE.
- Reset mid-RUN (P=9, `count_q`=5): drive `reset` low between edges.
  - outputs go immediately to `load_en`=1, `d`=0, `busy`=0, `expire`=0, `fault`=0.
  - no activity until the next `start`.
- Fault path: force `count_q`=0 during RUN. Next cycle IDLE, `fault`=1, and no `expire` is produced.
